// File: rtl/square_wave_envelope_gate.sv
// Transistor-gate / RC envelope applied to the square-wave oscillator output.
// Optional: ENV_GATE_RETRIGGER_EN lets trigger restart the attack while decaying.
package square_wave_envelope_gate_pkg;
  // Q0.16 RC step coefficient 65536*(1-exp(-1/(sr*tau))), clamped to 1..65535
  function automatic int calc_k(input int sr, input real tau);
    real x;
    real term;
    real sum;
    int  k;
    x = 1.0 / (real'(sr) * tau);
    if (x > 12.0) return 65535;
    term = x;
    sum  = 0.0;
    for (int n = 1; n <= 80; n++) begin
      sum  = sum + term;
      term = -term * x / real'(n + 1);
    end
    k = $rtoi(65536.0 * sum);
    if (k < 1) k = 1;
    else if (k > 65535) k = 65535;
    return k;
  endfunction
endpackage

module square_wave_envelope_gate #(
  parameter int  SIGNAL_FRACTION_WIDTH = 14,
  parameter int  SAMPLE_RATE           = 48000,
  parameter real ATTACK_TAU            = 0.001,
  parameter real DECAY_TAU             = 0.05,
  parameter int  ATTACK_K              = square_wave_envelope_gate_pkg::calc_k(SAMPLE_RATE, ATTACK_TAU),
  parameter int  DECAY_K               = square_wave_envelope_gate_pkg::calc_k(SAMPLE_RATE, DECAY_TAU),
  parameter int  SUSTAIN_MARGIN        = 64,
  parameter int  DECAY_FLOOR           = 16,
  localparam int W                     = SIGNAL_FRACTION_WIDTH + 2
) (
  input  logic                clk,
  input  logic                I_RST,
  input  logic                audio_clk_en,
  input  logic                trigger,
  input  logic signed [W-1:0] in,
  output logic signed [W-1:0] out,
  output logic [15:0]         env,
  output logic [1:0]          state,
  output logic                active
);
  localparam logic [15:0] ENV_MAX = 16'd32768;
  localparam logic [15:0] MARGIN  = 16'(SUSTAIN_MARGIN);
  localparam logic [15:0] FLOOR   = 16'(DECAY_FLOOR);
  localparam logic [15:0] AK      = 16'(ATTACK_K);
  localparam logic [15:0] DK      = 16'(DECAY_K);

  typedef enum logic [1:0] {IDLE = 2'b00, ATTACK = 2'b01, SUSTAIN = 2'b10, DECAY = 2'b11} state_t;

  state_t              st, st_nxt;
  logic [15:0]         env_q, env_nxt;
  logic signed [W-1:0] out_q;

  logic [15:0] att_d, att_step, env_att, dec_step, env_dec;
  logic [31:0] att_prod, dec_prod;
  logic [16:0] att_sum;
  logic signed [W+16:0] mix_prod;

  // One RC step toward ENV_MAX and toward 0; minimum step of 1 keeps both converging
  always_comb begin
    att_d    = ENV_MAX - env_q;
    att_prod = att_d * AK;
    att_step = att_prod[31:16];
    if (att_step == 16'd0 && att_d != 16'd0) att_step = 16'd1;
    att_sum  = {1'b0, env_q} + {1'b0, att_step};
    env_att  = (att_sum > {1'b0, ENV_MAX}) ? ENV_MAX : att_sum[15:0];

    dec_prod = env_q * DK;
    dec_step = dec_prod[31:16];
    if (dec_step == 16'd0 && env_q != 16'd0) dec_step = 16'd1;
    env_dec  = (dec_step > env_q) ? 16'd0 : env_q - dec_step;
  end

  // Gain uses the envelope from before this strobe's update
  assign mix_prod = in * $signed({1'b0, env_q});

  always_comb begin
    st_nxt  = st;
    env_nxt = env_q;
    case (st)
      IDLE: begin
        env_nxt = 16'd0;
        if (trigger) begin
          st_nxt  = ATTACK;
          env_nxt = env_att;
        end
      end
      ATTACK: begin
        if (!trigger) begin
          st_nxt  = DECAY;
          env_nxt = env_dec;
        end else if ((ENV_MAX - env_att) <= MARGIN) begin
          st_nxt  = SUSTAIN;
          env_nxt = ENV_MAX;
        end else begin
          env_nxt = env_att;
        end
      end
      SUSTAIN: begin
        env_nxt = ENV_MAX;
        if (!trigger) begin
          st_nxt  = DECAY;
          env_nxt = env_dec;
        end
      end
      DECAY: begin
`ifdef ENV_GATE_RETRIGGER_EN
        if (trigger) begin
          st_nxt  = ATTACK;
          env_nxt = env_att;
        end else
`endif
        if (env_dec <= FLOOR) begin
          st_nxt  = IDLE;
          env_nxt = 16'd0;
        end else begin
          env_nxt = env_dec;
        end
      end
      default: begin
        st_nxt  = IDLE;
        env_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (I_RST) begin
      st    <= IDLE;
      env_q <= 16'd0;
      out_q <= '0;
    end else if (audio_clk_en) begin
      st    <= st_nxt;
      env_q <= env_nxt;
      out_q <= mix_prod[W+14:15];
    end
  end

  assign out    = out_q;
  assign env    = env_q;
  assign state  = st;
  assign active = (st != IDLE);
endmodule

// File: tb/tb_square_wave_envelope_gate.sv
// Directed bench for square_wave_envelope_gate with ATTACK_K = DECAY_K = 0.5 (Q0.16).
module tb_square_wave_envelope_gate;
  logic clk = 1'b0;
  logic I_RST, audio_clk_en, trigger;
  logic signed [15:0] in, out;
  logic [15:0] env;
  logic [1:0]  state;
  logic        active;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  square_wave_envelope_gate #(.ATTACK_K(32768), .DECAY_K(32768)) dut (
    .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en), .trigger(trigger),
    .in(in), .out(out), .env(env), .state(state), .active(active)
  );

  typedef struct {
    logic rst, en, trig;
    int   din, o, e, s;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic t, input int d);
    I_RST = r; audio_clk_en = e; trigger = t; in = 16'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int o, input int e, input int s);
    chk({tag, " out"},    int'(out),    o);
    chk({tag, " env"},    int'(env),    e);
    chk({tag, " state"},  int'(state),  s);
    chk({tag, " active"}, int'(active), (s != 0) ? 1 : 0);
  endtask

  initial begin
    int n;
    I_RST = 1'b1; audio_clk_en = 1'b0; trigger = 1'b0; in = '0;

    // rst en trig in | out env state
    repeat (3) tv.push_back('{1'b1, 1'b1, 1'b1, 16384, 0, 0, 0});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,      0, 16384, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,   8192, 24576, 1});
    tv.push_back('{1'b0, 1'b0, 1'b1,   100,   8192, 24576, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  12288, 28672, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  14336, 30720, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  15360, 31744, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  15872, 32256, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  16128, 32512, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  16256, 32640, 1});
    tv.push_back('{1'b0, 1'b1, 1'b1, 16384,  16320, 32768, 2});
    tv.push_back('{1'b0, 1'b1, 1'b1, -12000, -12000, 32768, 2});
    tv.push_back('{1'b0, 1'b0, 1'b1,     5, -12000, 32768, 2});
    tv.push_back('{1'b0, 1'b1, 1'b1, -12000, -12000, 32768, 2});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,  16384, 16384, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,   8192,  8192, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,   4096,  4096, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,   2048,  2048, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,   1024,  1024, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,    512,   512, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,    256,   256, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,    128,   128, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,     64,    64, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,     32,    32, 3});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,     16,     0, 0});
    tv.push_back('{1'b0, 1'b1, 1'b0, 16384,      0,     0, 0});

    foreach (tv[i]) begin
      step(tv[i].rst, tv[i].en, tv[i].trig, tv[i].din);
      chk_all($sformatf("vec%0d", i), tv[i].o, tv[i].e, tv[i].s);
    end

    // Retrigger at env=8192 during decay
    step(1'b1, 1'b1, 1'b0, 0);
    repeat (9) step(1'b0, 1'b1, 1'b1, 16384);
    chk("retrig sustain state", int'(state), 2);
    step(1'b0, 1'b1, 1'b0, 16384);
    step(1'b0, 1'b1, 1'b0, 16384);
    chk("retrig decay env", int'(env), 8192);
    chk("retrig decay state", int'(state), 3);
    step(1'b0, 1'b1, 1'b1, 16384);
`ifdef ENV_GATE_RETRIGGER_EN
    chk("retrig state", int'(state), 1);
    chk("retrig env", int'(env), 20480);
    step(1'b0, 1'b1, 1'b1, 16384);
    chk("retrig next env", int'(env), 26624);
    chk("retrig next state", int'(state), 1);
`else
    chk("noretrig state", int'(state), 3);
    chk("noretrig env", int'(env), 4096);
    n = 0;
    while (state == 2'b11 && n < 20) begin
      step(1'b0, 1'b1, 1'b1, 16384);
      n++;
    end
    chk("noretrig strobes to idle", n, 8);
    chk("noretrig idle state", int'(state), 0);
    chk("noretrig idle env", int'(env), 0);
    step(1'b0, 1'b1, 1'b1, 16384);
    chk("noretrig attack state", int'(state), 1);
    chk("noretrig attack env", int'(env), 16384);
`endif

    // Reset mid-attack with the strobe low
    step(1'b1, 1'b1, 1'b1, 16384);
    step(1'b0, 1'b1, 1'b1, 16384);
    step(1'b0, 1'b1, 1'b1, 16384);
    chk_all("midattack", 8192, 24576, 1);
    step(1'b1, 1'b0, 1'b1, 16384);
    chk_all("midreset", 0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 16384);
    chk_all("midreset hold", 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
